frame_unloader_n_m: RTL and testbench
=====================================

# frame_unloader_n_m

Downstream consumer of the asynchronous m-entry FIFO buffer. It watches the FIFO's full flag and, once a full frame is present, snapshots the m parallel words. It then signals the FIFO that the frame is taken and streams the words out one per beat on a valid/ready interface, appending an XOR checksum and a frame counter. It runs entirely in the system clock domain; the full flag is synchronised internally.

## Interface
- n, 32, word width
- m, 16, words per frame (≥2)
- CNT_W, 16, frame counter width

- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-high reset; one clock, all state reset asynchronously
- data_i  in  n × [0:m-1]  FIFO parallel buffer; index 0 = oldest word
- full_i  in  1  FIFO full flag; asynchronous to clk_i, level
- ena_rd_o  out  1  frame-taken request to the FIFO, level
- out_data_o  out  n  streamed word
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  sink accepts the current beat
- out_last_o  out  1  current beat is word m-1
- out_sum_o  out  n  XOR of all m words of the frame; valid when out_last_o=1
- frame_cnt_o  out  CNT_W  frames fully streamed; wraps
- busy_o  out  1  state ≠ IDLE
- overrun_o  out  1  sticky: a frame was lost

## Operation
- full_i passes through a 2-flop synchroniser → full_s; a rise detector (full_s & ~full_s_d) gives full_rise.
- FSM states IDLE, CAPTURE, STREAM, WAIT_REL:
  - IDLE: on full_rise → CAPTURE.
  - CAPTURE (1 cycle): latch data_i[0:m-1] into snap[0:m-1]; clear idx and the running sum; assert ena_rd_o; → STREAM.
  - STREAM: out_data_o = snap[idx] and out_valid_o = 1. On out_valid_o & out_ready_i: idx+1 and sum ^= word. On the beat with idx = m-1: out_last_o = 1, out_sum_o = sum ^ snap[m-1], frame_cnt_o+1, → WAIT_REL.
  - WAIT_REL: ena_rd_o held; when full_s = 0 → IDLE and ena_rd_o drops.
- ena_rd_o = 1 in CAPTURE, STREAM and WAIT_REL.
- Overrun: in STREAM, full_s falling then rising again (a second full frame before the current one is done) sets overrun_o. The second frame is not captured; overrun_o clears only on rst_i.
- idx width is $clog2(m). idx never exceeds m-1; it returns to 0 only in CAPTURE.
- frame_cnt_o wraps from all-ones to 0 without a flag.

## Timing
- Reset values: state IDLE, all outputs 0, snap/idx/sum/synchroniser 0.
- full_i rise → full_rise 2–3 clk_i cycles later (synchroniser). CAPTURE is the next cycle. The first out_valid_o is on the cycle after CAPTURE.
- With out_ready_i held at 1: m beats in m consecutive cycles. frame_cnt_o updates on the cycle after the last beat.
- Valid/ready rules:
  - out_valid_o is never withdrawn before acceptance.
  - out_data_o, out_last_o and out_sum_o are stable while out_valid_o & ~out_ready_i.
  - All outputs are registered; there is no combinational path from out_ready_i to outputs.
- data_i is sampled only in CAPTURE. The FIFO holds it stable while full_i = 1.
- Reset mid-frame: the frame is abandoned, ena_rd_o drops, and no partial count is kept. If full_i is still high after reset, the synchroniser rises from 0, so the frame is re-captured from word 0.
- full_s dropping during STREAM does not abort the stream. It only arms overrun detection.

## Structure
- Package frame_unloader_pkg: state enum (IDLE, CAPTURE, STREAM, WAIT_REL) and the constant SYNC_STAGES = 2.
- One sub-module, sync_ff_2: a 2-flop level synchroniser with async active-high reset, instantiated for full_i.
- Snapshot is a register array n × m; no RAM.

## Test plan
- Reset, then raise full_i with data_i[k] = 32'h100+k, m=16, out_ready_i=1 → ena_rd_o high; 16 consecutive beats 0x100…0x10F; out_last_o on 0x10F; out_sum_o = 0x000; frame_cnt_o = 1.
- Same frame with out_ready_i toggling 1,0,0,1 → each word held stable while ready=0; order unchanged; total 16 accepted beats.
- During STREAM, drop full_i for 4 cycles then raise it again → overrun_o = 1 and stays 1; current frame completes; no second CAPTURE until full_s falls and rises in IDLE.
- Assert rst_i at beat 7, with full_i held high → all outputs 0 immediately; after release, stream restarts at data_i[0]; frame_cnt_o = 1 at the end.
- Preload frame_cnt_o to 16'hFFFF via 65535 short frames (m=2 build) → next frame gives frame_cnt_o = 0.
- data_i = {0xFFFFFFFF, 0x0F0F0F0F, rest 0} → out_sum_o = 0xF0F0F0F0 on the last beat.

Source files
------------

// File: rtl/frame_unloader_n_m_pkg.sv
// frame_unloader_pkg: shared FSM state type and synchroniser depth for the frame unloader
package frame_unloader_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, WAIT_REL} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/frame_unloader_n_m_if.sv
// frame_unloader_n_m_if: FIFO-side and stream-side signals of the frame unloader
//   data_i/full_i     parallel frame and full flag from the FIFO (index 0 = oldest word)
//   ena_rd_o          frame-taken level back to the FIFO
//   out_*             valid/ready word stream with last flag and XOR checksum
//   frame_cnt_o       wrapping count of fully streamed frames
//   busy_o/overrun_o  FSM not idle / sticky lost-frame flag
//   master = unloader side, slave = FIFO and sink side
interface frame_unloader_n_m_if #(parameter int N = 32, parameter int M = 16, parameter int CNT_W = 16);
  logic [0:M-1][N-1:0] data_i;
  logic full_i, ena_rd_o, out_valid_o, out_ready_i, out_last_o, busy_o, overrun_o;
  logic [N-1:0] out_data_o, out_sum_o;
  logic [CNT_W-1:0] frame_cnt_o;
  modport master (input data_i, full_i, out_ready_i,
                  output ena_rd_o, out_data_o, out_valid_o, out_last_o, out_sum_o, frame_cnt_o, busy_o, overrun_o);
  modport slave (output data_i, full_i, out_ready_i,
                 input ena_rd_o, out_data_o, out_valid_o, out_last_o, out_sum_o, frame_cnt_o, busy_o, overrun_o);
endinterface

// File: rtl/frame_unloader_n_m_sync.sv
// sync_ff_2: two-flop level synchroniser with asynchronous active-high reset
//   clk_i/rst_i  destination clock and reset
//   i_d          asynchronous level input
//   o_q          synchronised level
module sync_ff_2
  import frame_unloader_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_STAGES-1:0] r_sh;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_sh <= '0;
    else r_sh <= {r_sh[SYNC_STAGES-2:0], i_d};
  assign o_q = r_sh[SYNC_STAGES-1];
endmodule

// File: rtl/frame_unloader_n_m.sv
// frame_unloader_n_m: snapshots a full FIFO frame and streams it word by word with XOR checksum and frame count
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   bus    frame_unloader_n_m_if master modport (FIFO frame in, word stream out, status)
module frame_unloader_n_m
  import frame_unloader_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 16,
  parameter int CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  frame_unloader_n_m_if.master bus
);
  localparam int IW = $clog2(M);
  state_t              r_state;
  logic [0:M-1][N-1:0] r_snap;
  logic [IW-1:0]       r_idx;
  logic [N-1:0]        r_sum, r_out_data, r_out_sum;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic                r_busy, r_out_valid, r_out_last, r_overrun, r_armed, r_full_d;
  logic                w_full_s, w_full_rise;
  logic [IW-1:0]       w_idx_nxt;
  logic [N-1:0]        w_sum_nxt;
  sync_ff_2 u_sync (.clk_i(clk_i), .rst_i(rst_i), .i_d(bus.full_i), .o_q(w_full_s));
  assign w_full_rise = w_full_s & ~r_full_d;
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_sum_nxt   = r_sum ^ r_snap[r_idx];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_full_d    <= 1'b0;
      r_busy      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_sum   <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_full_d <= w_full_s;
      case (r_state)
        IDLE: if (w_full_rise) begin
          r_state <= CAPTURE;
          r_busy  <= 1'b1;
        end
        CAPTURE: begin
          r_snap      <= bus.data_i;
          r_idx       <= '0;
          r_sum       <= '0;
          r_armed     <= 1'b0;
          r_out_data  <= bus.data_i[0];
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_state     <= STREAM;
        end
        STREAM: begin
          // a fall of full_s mid-stream arms detection of a second, uncapturable frame
          if (!w_full_s) r_armed <= 1'b1;
          if (r_armed && w_full_rise) r_overrun <= 1'b1;
          if (bus.out_ready_i) begin
            r_sum <= w_sum_nxt;
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 1'b1;
              r_state     <= WAIT_REL;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_data <= r_snap[w_idx_nxt];
              r_out_last <= w_idx_nxt == IW'(M - 1);
              // precomputed so the checksum is already complete when the last word is shown
              r_out_sum  <= w_sum_nxt ^ r_snap[w_idx_nxt];
            end
          end
        end
        WAIT_REL: if (!w_full_s) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  // the frame-taken request is held exactly while the FSM is out of IDLE
  assign bus.ena_rd_o    = r_busy;
  assign bus.busy_o      = r_busy;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_valid_o = r_out_valid;
  assign bus.out_last_o  = r_out_last;
  assign bus.out_sum_o   = r_out_sum;
  assign bus.frame_cnt_o = r_frame_cnt;
  assign bus.overrun_o   = r_overrun;
endmodule

// File: tb/tb_frame_unloader_n_m.sv
// tb_frame_unloader_n_m: directed checks of the frame unloader (m=16 build plus m=2/CNT_W=4 build for wrap)
module tb_frame_unloader_n_m;
  logic clk = 1'b0, rst = 1'b0;
  int n_tests = 0, n_fail = 0;
  logic [31:0] got_d [16];
  logic        got_l [16];
  logic [31:0] got_sum;
  int got_n, stall_bad, span;

  always #5 clk = ~clk;

  frame_unloader_n_m_if #(.N(32), .M(16), .CNT_W(16)) a();
  frame_unloader_n_m_if #(.N(32), .M(2), .CNT_W(4)) b();
  frame_unloader_n_m #(.N(32), .M(16), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a.master));
  frame_unloader_n_m #(.N(32), .M(2), .CNT_W(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b.master));

  task automatic load_inc();
    for (int k = 0; k < 16; k++) a.data_i[k] = 32'h100 + k;
  endtask

  // drives ready from a 4-cycle pattern and records accepted beats of DUT a
  task automatic collect(input logic [3:0] pat, input int nmax);
    int k = 0, cyc = 0, first = -1;
    logic hold = 1'b0;
    logic [31:0] held = '0;
    got_n = 0; stall_bad = 0; span = 0; got_sum = '0;
    while (got_n < nmax && cyc < 200) begin
      @(negedge clk); cyc++;
      a.out_ready_i = pat[k % 4]; k++;
      if (hold && (a.out_valid_o !== 1'b1 || a.out_data_o !== held)) stall_bad++;
      hold = 1'b0;
      if (a.out_valid_o === 1'b1) begin
        if (first < 0) first = cyc;
        if (a.out_ready_i) begin
          got_d[got_n] = a.out_data_o;
          got_l[got_n] = a.out_last_o;
          if (a.out_last_o) got_sum = a.out_sum_o;
          got_n++;
          span = cyc - first + 1;
        end else begin
          hold = 1'b1;
          held = a.out_data_o;
        end
      end
    end
  endtask

  task automatic release_a();
    int t = 0;
    a.full_i = 1'b0;
    while (a.busy_o !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    n_tests++;
    if (a.busy_o !== 1'b0) begin n_fail++; $display("FAIL release_timeout busy=%b exp 0", a.busy_o); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({a.ena_rd_o, a.out_valid_o, a.out_last_o, a.busy_o, a.overrun_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00000", {a.ena_rd_o, a.out_valid_o, a.out_last_o, a.busy_o, a.overrun_o});
    end
    n_tests++;
    if ({a.out_data_o, a.out_sum_o, a.frame_cnt_o} !== 80'b0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h exp 0", a.out_data_o, a.out_sum_o, a.frame_cnt_o);
    end
    n_tests++;
    if (b.frame_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_cnt_b got %h exp 0", b.frame_cnt_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_inc();
    a.full_i = 1'b1;
    collect(4'b1111, 16);
    n_tests++;
    if (got_n !== 16) begin n_fail++; $display("FAIL basic_beats got %0d exp 16", got_n); end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_d[i] !== 32'h100 + i || got_l[i] !== (i == 15)) begin
        n_fail++; $display("FAIL basic_word%0d got %h last %b exp %h last %b", i, got_d[i], got_l[i], 32'h100 + i, i == 15);
      end
    end
    n_tests++;
    if (span !== 16) begin n_fail++; $display("FAIL basic_span got %0d exp 16", span); end
    n_tests++;
    if (got_sum !== 32'h0) begin n_fail++; $display("FAIL basic_sum got %h exp 00000000", got_sum); end
    n_tests++;
    if (a.ena_rd_o !== 1'b1) begin n_fail++; $display("FAIL basic_ena_rd got %b exp 1", a.ena_rd_o); end
    @(negedge clk);
    n_tests++;
    if (a.frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL basic_cnt got %0d exp 1", a.frame_cnt_o); end
    release_a();
    n_tests++;
    if (a.ena_rd_o !== 1'b0) begin n_fail++; $display("FAIL basic_ena_drop got %b exp 0", a.ena_rd_o); end
  endtask

  task automatic test_backpressure();
    a.full_i = 1'b1;
    collect(4'b1001, 16);
    n_tests++;
    if (got_n !== 16) begin n_fail++; $display("FAIL bp_beats got %0d exp 16", got_n); end
    for (int i = 0; i < got_n; i++) begin
      n_tests++;
      if (got_d[i] !== 32'h100 + i) begin n_fail++; $display("FAIL bp_word%0d got %h exp %h", i, got_d[i], 32'h100 + i); end
    end
    n_tests++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_bad); end
    @(negedge clk);
    n_tests++;
    if (a.frame_cnt_o !== 16'd2) begin n_fail++; $display("FAIL bp_cnt got %0d exp 2", a.frame_cnt_o); end
    release_a();
  endtask

  task automatic test_overrun();
    int t = 0, extra = 0;
    a.out_ready_i = 1'b0;
    a.full_i = 1'b1;
    while (a.out_valid_o !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    a.full_i = 1'b0;
    repeat (4) @(negedge clk);
    a.full_i = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (a.overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b exp 1", a.overrun_o); end
    n_tests++;
    if (a.out_valid_o !== 1'b1 || a.out_data_o !== 32'h100) begin
      n_fail++; $display("FAIL ovr_hold valid %b data %h exp 1 00000100", a.out_valid_o, a.out_data_o);
    end
    collect(4'b1111, 16);
    n_tests++;
    if (got_n !== 16 || got_d[0] !== 32'h100 || got_d[15] !== 32'h10F) begin
      n_fail++; $display("FAIL ovr_frame beats %0d first %h last %h exp 16 100 10f", got_n, got_d[0], got_d[15]);
    end
    @(negedge clk);
    n_tests++;
    if (a.frame_cnt_o !== 16'd3) begin n_fail++; $display("FAIL ovr_cnt got %0d exp 3", a.frame_cnt_o); end
    repeat (10) begin @(negedge clk); if (a.out_valid_o !== 1'b0) extra++; end
    n_tests++;
    if (extra !== 0 || a.busy_o !== 1'b1) begin n_fail++; $display("FAIL ovr_no_recapture valid cycles %0d busy %b exp 0 1", extra, a.busy_o); end
    release_a();
    n_tests++;
    if (a.overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b exp 1", a.overrun_o); end
  endtask

  task automatic test_reset_mid();
    a.full_i = 1'b1;
    collect(4'b1111, 7);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({a.ena_rd_o, a.out_valid_o, a.busy_o, a.overrun_o} !== 4'b0 || a.frame_cnt_o !== 16'd0 || a.out_data_o !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_clear flags %b cnt %0d data %h exp 0", {a.ena_rd_o, a.out_valid_o, a.busy_o, a.overrun_o}, a.frame_cnt_o, a.out_data_o);
    end
    @(negedge clk);
    rst = 1'b0;
    collect(4'b1111, 16);
    n_tests++;
    if (got_n !== 16 || got_d[0] !== 32'h100 || got_d[15] !== 32'h10F) begin
      n_fail++; $display("FAIL rstmid_restart beats %0d first %h last %h exp 16 100 10f", got_n, got_d[0], got_d[15]);
    end
    @(negedge clk);
    n_tests++;
    if (a.frame_cnt_o !== 16'd1) begin n_fail++; $display("FAIL rstmid_cnt got %0d exp 1", a.frame_cnt_o); end
    release_a();
  endtask

  task automatic test_checksum();
    for (int k = 0; k < 16; k++) a.data_i[k] = 32'h0;
    a.data_i[0] = 32'hFFFF_FFFF;
    a.data_i[1] = 32'h0F0F_0F0F;
    a.full_i = 1'b1;
    collect(4'b1111, 16);
    n_tests++;
    if (got_n !== 16 || got_d[1] !== 32'h0F0F_0F0F || got_l[15] !== 1'b1) begin
      n_fail++; $display("FAIL sum_frame beats %0d w1 %h last %b exp 16 0f0f0f0f 1", got_n, got_d[1], got_l[15]);
    end
    n_tests++;
    if (got_sum !== 32'hF0F0_F0F0) begin n_fail++; $display("FAIL sum_value got %h exp f0f0f0f0", got_sum); end
    release_a();
  endtask

  task automatic test_wrap();
    int tmo = 0;
    logic [31:0] sum_b = '0;
    b.data_i[0] = 32'hA5A5_A5A5;
    b.data_i[1] = 32'h0000_FFFF;
    b.out_ready_i = 1'b1;
    for (int f = 1; f <= 16; f++) begin
      int t = 0;
      b.full_i = 1'b1;
      while (!(b.out_valid_o === 1'b1 && b.out_last_o === 1'b1) && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) tmo++;
      sum_b = b.out_sum_o;
      b.full_i = 1'b0;
      t = 0;
      @(negedge clk);
      while (b.busy_o !== 1'b0 && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) tmo++;
      if (f == 15) begin
        n_tests++;
        if (b.frame_cnt_o !== 4'hF) begin n_fail++; $display("FAIL wrap_full got %h exp f", b.frame_cnt_o); end
      end
    end
    n_tests++;
    if (b.frame_cnt_o !== 4'h0) begin n_fail++; $display("FAIL wrap_zero got %h exp 0", b.frame_cnt_o); end
    n_tests++;
    if (sum_b !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL wrap_sum got %h exp a5a55a5a", sum_b); end
    n_tests++;
    if (tmo !== 0) begin n_fail++; $display("FAIL wrap_timeout got %0d expired waits exp 0", tmo); end
  endtask

  initial begin
    a.full_i = 1'b0; a.out_ready_i = 1'b0; a.data_i = '0;
    b.full_i = 1'b0; b.out_ready_i = 1'b0; b.data_i = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_checksum();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
